// File: rtl/udp_vid_pkg.sv
`default_nettype none
// =============================================================================
// udp_vid_pkg : shared types and constants for the UDP video line unpacker.
// Rev 1.0
// =============================================================================
package udp_vid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_HDR  = 2'b01;
  localparam logic [1:0] ERR_LINE = 2'b10;
  localparam logic [1:0] ERR_ODD  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [15:0] HDR_OFS_FLAGS   = 16'd1;
  localparam logic [15:0] HDR_OFS_LINE_HI = 16'd2;
  localparam logic [15:0] HDR_OFS_LINE_LO = 16'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_vid_byte2pix.sv
`default_nettype none
// =============================================================================
// udp_vid_byte2pix : pairs big-endian bytes into RGB565 pixels and counts x,
//                    ignoring bytes once H_ACTIVE pixels have been produced.
// Rev 1.0
// =============================================================================
module udp_vid_byte2pix #(
  parameter int H_ACTIVE = 1280
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic        i_sof,
  output logic [15:0] o_pix_data,
  output logic        o_pix_valid,
  output logic [11:0] o_pix_x,
  output logic        o_frame_start,
  output logic        o_full,
  output logic        o_half
);

  localparam logic [11:0] c_H_ACTIVE = 12'(H_ACTIVE);

  logic [7:0]  r_hi;
  logic        r_half;
  logic [11:0] r_cnt;
  logic [15:0] r_pix_data;
  logic        r_pix_valid;
  logic [11:0] r_pix_x;
  logic        r_fs;
  logic        w_full;

  assign w_full = (r_cnt == c_H_ACTIVE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hi        <= 8'd0;
      r_half      <= 1'b0;
      r_cnt       <= 12'd0;
      r_pix_data  <= 16'd0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= 12'd0;
      r_fs        <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      r_fs        <= 1'b0;
      if (i_clr) begin
        r_half <= 1'b0;
        r_cnt  <= 12'd0;
      end else if (i_en && !w_full) begin
        if (!r_half) begin
          r_hi   <= i_byte;
          r_half <= 1'b1;
        end else begin
          r_pix_data  <= {r_hi, i_byte};
          r_pix_valid <= 1'b1;
          r_pix_x     <= r_cnt;
          r_fs        <= i_sof && (r_cnt == 12'd0);
          r_cnt       <= r_cnt + 12'd1;
          r_half      <= 1'b0;
        end
      end
    end
  end

  assign o_pix_data    = r_pix_data;
  assign o_pix_valid   = r_pix_valid;
  assign o_pix_x       = r_pix_x;
  assign o_frame_start = r_fs;
  assign o_full        = w_full;
  assign o_half        = r_half;

endmodule
`default_nettype wire

// File: rtl/udp_video_unpack.sv
`default_nettype none
// =============================================================================
// udp_video_unpack : parses a 4-byte video line header from a UDP payload
//                    stream and emits x/y-tagged RGB565 pixels; drops bad lines.
// Optional: define UDP_VID_STATS_EN for stat_lines / stat_drops counters.
// Rev 1.0
// =============================================================================
module udp_video_unpack
  import udp_vid_pkg::*;
#(
  parameter int         H_ACTIVE  = 1280,
  parameter int         V_ACTIVE  = 720,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic        line_done,
  output logic        err_pulse,
  output logic [1:0]  err_code
`ifdef UDP_VID_STATS_EN
  ,
  output logic [31:0] stat_lines,
  output logic [31:0] stat_drops
`endif
);

  localparam logic [15:0] c_V_ACTIVE = 16'(V_ACTIVE);

  state_t      r_state;
  logic        r_valid_d;
  logic [15:0] r_byte_cnt;
  logic        r_sof;
  logic [7:0]  r_line_hi;
  logic [11:0] r_pix_y;
  logic        r_ovf;
  logic        r_line_done;
  logic        r_err_pulse;
  logic [1:0]  r_err_code;

  logic        w_start;
  logic [15:0] w_line;
  logic        w_full;
  logic        w_half;
  logic        w_clr;
  logic        w_en;

  assign w_start = in_valid && !r_valid_d;
  assign w_line  = {r_line_hi, in_data};
  // Pixel pairing state is held cleared outside PIX so every line starts at x=0.
  assign w_clr   = (r_state != PIX);
  assign w_en    = (r_state == PIX) && in_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_valid_d   <= 1'b0;
      r_byte_cnt  <= 16'd0;
      r_sof       <= 1'b0;
      r_line_hi   <= 8'd0;
      r_pix_y     <= 12'd0;
      r_ovf       <= 1'b0;
      r_line_done <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_valid_d   <= in_valid;
      r_line_done <= 1'b0;
      r_err_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_byte_cnt <= 16'd1;
            r_ovf      <= 1'b0;
            if (in_data != SYNC_BYTE) begin
              r_state     <= DROP;
              r_err_pulse <= 1'b1;
              r_err_code  <= ERR_HDR;
            end else begin
              r_state <= HDR;
            end
          end
        end
        HDR: begin
          if (!in_valid) begin
            r_state     <= IDLE;
            r_err_pulse <= 1'b1;
            r_err_code  <= ERR_HDR;
          end else begin
            r_byte_cnt <= sat_inc16(r_byte_cnt);
            case (r_byte_cnt)
              HDR_OFS_FLAGS:   r_sof     <= in_data[0];
              HDR_OFS_LINE_HI: r_line_hi <= in_data;
              HDR_OFS_LINE_LO: begin
                if (w_line >= c_V_ACTIVE) begin
                  r_state     <= DROP;
                  r_err_pulse <= 1'b1;
                  r_err_code  <= ERR_LINE;
                end else begin
                  r_pix_y <= w_line[11:0];
                  r_state <= PIX;
                end
              end
              default: ;
            endcase
          end
        end
        PIX: begin
          if (!in_valid) begin
            r_state <= IDLE;
            if (r_ovf || w_half) begin
              r_err_pulse <= 1'b1;
              r_err_code  <= ERR_ODD;
            end else begin
              r_line_done <= 1'b1;
            end
          end else begin
            r_byte_cnt <= sat_inc16(r_byte_cnt);
            if (w_full) r_ovf <= 1'b1;
          end
        end
        DROP: begin
          if (!in_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  udp_vid_byte2pix #(
    .H_ACTIVE (H_ACTIVE)
  ) u_byte2pix (
    .clk           (clk),
    .rstn          (rstn),
    .i_clr         (w_clr),
    .i_en          (w_en),
    .i_byte        (in_data),
    .i_sof         (r_sof),
    .o_pix_data    (pix_data),
    .o_pix_valid   (pix_valid),
    .o_pix_x       (pix_x),
    .o_frame_start (frame_start),
    .o_full        (w_full),
    .o_half        (w_half)
  );

  assign pix_y     = r_pix_y;
  assign line_done = r_line_done;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;

`ifdef UDP_VID_STATS_EN
  logic [31:0] r_stat_lines;
  logic [31:0] r_stat_drops;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_lines <= 32'd0;
      r_stat_drops <= 32'd0;
    end else begin
      if (r_line_done) r_stat_lines <= r_stat_lines + 32'd1;
      if (r_err_pulse) r_stat_drops <= r_stat_drops + 32'd1;
    end
  end

  assign stat_lines = r_stat_lines;
  assign stat_drops = r_stat_drops;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_video_unpack.sv
`default_nettype none
// =============================================================================
// tb_udp_video_unpack : directed table plus random datagrams against an
//                       event-level reference model; two DUTs (H_ACTIVE 1280 / 4).
// Rev 1.0
// =============================================================================
module tb_udp_video_unpack;

  localparam logic [1:0] K_PIX  = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [15:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } ev_t;

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           npix0, npix1;
    int           err0, err1;
    int           done0, done1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;

  logic [15:0] pd0, pd1;
  logic        pv0, pv1, fs0, fs1, ld0, ld1, ep0, ep1;
  logic [11:0] px0, px1, py0, py1;
  logic [1:0]  ec0, ec1;
`ifdef UDP_VID_STATS_EN
  logic [31:0] sl0, sd0, sl1, sd1;
`endif

  udp_video_unpack dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .pix_data(pd0), .pix_valid(pv0), .pix_x(px0), .pix_y(py0),
    .frame_start(fs0), .line_done(ld0), .err_pulse(ep0), .err_code(ec0)
`ifdef UDP_VID_STATS_EN
    , .stat_lines(sl0), .stat_drops(sd0)
`endif
  );

  udp_video_unpack #(.H_ACTIVE(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .pix_data(pd1), .pix_valid(pv1), .pix_x(px1), .pix_y(py1),
    .frame_start(fs1), .line_done(ld1), .err_pulse(ep1), .err_code(ec1)
`ifdef UDP_VID_STATS_EN
    , .stat_lines(sl1), .stat_drops(sd1)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t act0[$], act1[$], exp0[$], exp1[$];
  int checks = 0;
  int errors = 0;
  int stray = 0;
  vec_t tbl[8];
  logic [7:0] bq[$];

  function automatic ev_t mk(input logic [1:0] kind, input int c, input logic [15:0] d,
                             input logic [11:0] x, input logic [11:0] y, input logic fs);
    ev_t e;
    e.kind = kind; e.cyc = 32'(c); e.d = d; e.x = x; e.y = y; e.fs = fs;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (pv0) act0.push_back(mk(K_PIX, cyc, pd0, px0, py0, fs0));
      else if (fs0) stray++;
      if (ep0) act0.push_back(mk(K_ERR, cyc, 16'(ec0), 12'd0, 12'd0, 1'b0));
      if (ld0) act0.push_back(mk(K_DONE, cyc, 16'd0, 12'd0, 12'd0, 1'b0));
      if (pv1) act1.push_back(mk(K_PIX, cyc, pd1, px1, py1, fs1));
      else if (fs1) stray++;
      if (ep1) act1.push_back(mk(K_ERR, cyc, 16'(ec1), 12'd0, 12'd0, 1'b0));
      if (ld1) act1.push_back(mk(K_DONE, cyc, 16'd0, 12'd0, 12'd0, 1'b0));
    end
  end

  task automatic chk(input bit ok, input string nm, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  // Reference: the datagram's fate follows directly from its bytes and length.
  task automatic model(input int k, input logic [7:0] b[$], input int s);
    ev_t q[$];
    int n, h, line, nbody, npix;
    n = b.size();
    h = (k == 0) ? 1280 : 4;
    if (b[0] != 8'hA5) begin
      q.push_back(mk(K_ERR, s, 16'd1, 12'd0, 12'd0, 1'b0));
    end else if (n < 4) begin
      q.push_back(mk(K_ERR, s + n, 16'd1, 12'd0, 12'd0, 1'b0));
    end else begin
      line = int'({b[2], b[3]});
      if (line >= 720) begin
        q.push_back(mk(K_ERR, s + 3, 16'd2, 12'd0, 12'd0, 1'b0));
      end else begin
        nbody = n - 4;
        npix  = nbody / 2;
        if (npix > h) npix = h;
        for (int p = 0; p < npix; p++)
          q.push_back(mk(K_PIX, s + 5 + 2 * p, {b[4 + 2 * p], b[5 + 2 * p]},
                         12'(p), 12'(line), b[1][0] && (p == 0)));
        if (nbody > 2 * h || (nbody % 2) == 1)
          q.push_back(mk(K_ERR, s + n, 16'd3, 12'd0, 12'd0, 1'b0));
        else
          q.push_back(mk(K_DONE, s + n, 16'd0, 12'd0, 12'd0, 1'b0));
      end
    end
    foreach (q[i]) begin
      if (k == 0) exp0.push_back(q[i]);
      else        exp1.push_back(q[i]);
    end
  endtask

  task automatic send(input logic [7:0] b[$], input int gap, input bit do_model);
    int s;
    s = cyc + 1;
    if (do_model) begin
      model(0, b, s);
      model(1, b, s);
    end
    foreach (b[i]) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic compare(input int k, input string nm);
    ev_t a[$], e[$];
    int m;
    if (k == 0) begin a = act0; e = exp0; end
    else        begin a = act1; e = exp1; end
    chk(a.size() == e.size(), {nm, "_count"},
        $sformatf("dut%0d events got %0d want %0d", k, a.size(), e.size()));
    m = (a.size() < e.size()) ? a.size() : e.size();
    for (int i = 0; i < m; i++)
      chk(a[i] == e[i], $sformatf("%s_ev%0d", nm, i),
          $sformatf("dut%0d got k=%0d c=%0d d=%h x=%0d y=%0d fs=%0d want k=%0d c=%0d d=%h x=%0d y=%0d fs=%0d",
                    k, a[i].kind, a[i].cyc, a[i].d, a[i].x, a[i].y, a[i].fs,
                    e[i].kind, e[i].cyc, e[i].d, e[i].x, e[i].y, e[i].fs));
  endtask

  task automatic clear_q();
    act0.delete(); act1.delete(); exp0.delete(); exp1.delete();
  endtask

  function automatic int cnt_kind(input ev_t q[$], input logic [1:0] kind);
    int c;
    c = 0;
    foreach (q[i]) if (q[i].kind == kind) c++;
    return c;
  endfunction

  task automatic chk_entry(input int k, input int idx, input int npix, input int err, input int done);
    ev_t a[$];
    int lcode;
    logic [1:0] ec;
    if (k == 0) begin a = act0; ec = ec0; end
    else        begin a = act1; ec = ec1; end
    lcode = 0;
    foreach (a[i]) if (a[i].kind == K_ERR) lcode = int'(a[i].d);
    chk(cnt_kind(a, K_PIX) == npix, $sformatf("tbl%0d_npix%0d", idx, k),
        $sformatf("got %0d want %0d", cnt_kind(a, K_PIX), npix));
    chk(cnt_kind(a, K_ERR) == ((err != 0) ? 1 : 0), $sformatf("tbl%0d_nerr%0d", idx, k),
        $sformatf("got %0d want %0d", cnt_kind(a, K_ERR), (err != 0) ? 1 : 0));
    chk(cnt_kind(a, K_DONE) == done, $sformatf("tbl%0d_done%0d", idx, k),
        $sformatf("got %0d want %0d", cnt_kind(a, K_DONE), done));
    if (err != 0) begin
      chk(lcode == err, $sformatf("tbl%0d_code%0d", idx, k),
          $sformatf("got %0d want %0d", lcode, err));
      chk(int'(ec) == err, $sformatf("tbl%0d_held%0d", idx, k),
          $sformatf("got %0d want %0d", ec, err));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({pd0, pv0, px0, py0, fs0, ld0, ep0, ec0} == '0, {nm, "_dut"},
        $sformatf("got pd=%h pv=%b x=%0d y=%0d fs=%b ld=%b ep=%b ec=%0d want all 0",
                  pd0, pv0, px0, py0, fs0, ld0, ep0, ec0));
    chk({pd1, pv1, px1, py1, fs1, ld1, ep1, ec1} == '0, {nm, "_dut4"},
        $sformatf("got pd=%h pv=%b x=%0d y=%0d fs=%b ld=%b ep=%b ec=%0d want all 0",
                  pd1, pv1, px1, py1, fs1, ld1, ep1, ec1));
`ifdef UDP_VID_STATS_EN
    chk({sl0, sd0, sl1, sd1} == '0, {nm, "_stats"},
        $sformatf("got %0d %0d %0d %0d want 0", sl0, sd0, sl1, sd1));
`endif
  endtask

  initial begin
    int r, n, gap, line;

    tbl[0] = '{128'hA5010005F80007E0,                 8, 2, 2, 0, 0, 1, 1};
    tbl[1] = '{128'hA40000011122,                     6, 0, 0, 1, 1, 0, 0};
    tbl[2] = '{128'hA50002D000112233445566778899,    14, 0, 0, 2, 2, 0, 0};
    tbl[3] = '{128'hA50000031122334455,               9, 2, 2, 3, 3, 0, 0};
    tbl[4] = '{128'hA5010007000102030405060708090A0B, 16, 6, 4, 0, 3, 1, 0};
    tbl[5] = '{128'hA5800000,                         4, 0, 0, 0, 0, 1, 1};
    tbl[6] = '{128'hA50000,                           3, 0, 0, 1, 1, 0, 0};
    tbl[7] = '{128'hA50002CFBEEF,                     6, 1, 1, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      clear_q();
      bq.delete();
      for (int j = 0; j < tbl[i].len; j++)
        bq.push_back(tbl[i].bytes[8 * (tbl[i].len - 1 - j) +: 8]);
      send(bq, 4, 1'b1);
      chk_entry(0, i, tbl[i].npix0, tbl[i].err0, tbl[i].done0);
      chk_entry(1, i, tbl[i].npix1, tbl[i].err1, tbl[i].done1);
      compare(0, $sformatf("tbl%0d", i));
      compare(1, $sformatf("tbl%0d", i));
    end

    // Full-width line with one extra pixel beyond the limit on the 1280 instance.
    clear_q();
    bq.delete();
    bq.push_back(8'hA5); bq.push_back(8'h01); bq.push_back(8'h00); bq.push_back(8'h0A);
    for (int j = 0; j < 2562; j++) bq.push_back(8'($urandom_range(0, 255)));
    send(bq, 4, 1'b1);
    compare(0, "ovf");
    compare(1, "ovf");

    clear_q();
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      n = (r == 1) ? $urandom_range(1, 3) : 4 + $urandom_range(0, 20);
      bq.delete();
      for (int j = 0; j < n; j++) bq.push_back(8'($urandom_range(0, 255)));
      if (r != 0) bq[0] = 8'hA5;
      if (n >= 4) begin
        line = (r == 2) ? $urandom_range(720, 65535) : $urandom_range(0, 719);
        bq[2] = 8'(line >> 8);
        bq[3] = 8'(line);
      end
      gap = $urandom_range(1, 3);
      send(bq, gap, 1'b1);
    end
    repeat (4) begin @(posedge clk); #1; end
    compare(0, "rand");
    compare(1, "rand");

    // Back-to-back lines, then reset in the middle of a third line.
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    clear_q();
    bq.delete();
    bq = '{8'hA5, 8'h01, 8'h00, 8'h05, 8'hF8, 8'h00, 8'h07, 8'hE0};
    send(bq, 1, 1'b1);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h06, 8'h12, 8'h34, 8'h56, 8'h78};
    send(bq, 1, 1'b1);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h07, 8'hAB};
    foreach (bq[i]) begin
      in_valid = 1'b1;
      in_data  = bq[i];
      @(posedge clk); #1;
    end
`ifdef UDP_VID_STATS_EN
    chk(sl0 == 32'd2, "stat_lines", $sformatf("got %0d want 2", sl0));
    chk(sd0 == 32'd0, "stat_drops", $sformatf("got %0d want 0", sd0));
`endif
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    compare(0, "b2b");
    compare(1, "b2b");

    chk(stray == 0, "stray_frame_start", $sformatf("got %0d want 0", stray));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
